// File: rtl/md_step_sequencer.sv
// Front-end and timestep sequencer for the MD core: slow clock divider, particle
// record loader into per-cell BRAM write ports, and phase-1 / phase-3 step control.
module md_step_sequencer #(
    parameter int N_CELL   = 27,
    parameter int CELL_W   = 8,
    parameter int ADDR_W   = 9,
    parameter int PW       = 96,
    parameter int DIV_HALF = 8,
    parameter int SETTLE   = 99,
    parameter int STEP_W   = 16
) (
    input  logic                            fast_clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [15:0]                     cfg_n_particles,
    input  logic [STEP_W-1:0]               cfg_n_steps,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2*PW+CELL_W+ADDR_W-1:0]   in_data,
    input  logic                            phase1_done_in,
    input  logic [N_CELL-1:0]               phase3_done_in,
    output logic                            clk_div,
    output logic                            tick,
    output logic [N_CELL-1:0]               ld_we,
    output logic [ADDR_W-1:0]               ld_addr,
    output logic [PW:0]                     ld_pos,
    output logic [PW:0]                     ld_vel,
    output logic                            mem_set,
    output logic                            phase1_ready,
    output logic                            phase3_ready,
    output logic [STEP_W-1:0]               step_count,
    output logic                            busy,
    output logic                            done,
    output logic                            err_cell
);

    localparam int CNT_W = (DIV_HALF > 2) ? $clog2(DIV_HALF) : 1;
    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_P1,
        S_P3,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   div_cnt;
    logic [15:0]        load_cnt;
    logic [SET_W-1:0]   settle;

    logic               div_wrap;
    logic               load_pending;
    logic               transfer;
    logic [PW-1:0]      rec_pos;
    logic [PW-1:0]      rec_vel;
    logic [CELL_W-1:0]  rec_cell;
    logic [ADDR_W-1:0]  rec_addr;
    logic               rec_cell_ok;

    assign rec_pos  = in_data[PW-1:0];
    assign rec_vel  = in_data[2*PW-1:PW];
    assign rec_cell = in_data[2*PW +: CELL_W];
    assign rec_addr = in_data[2*PW+CELL_W +: ADDR_W];
    assign rec_cell_ok = ({1'b0, rec_cell} < (CELL_W+1)'(N_CELL));

    // tick marks the fast edge on which clk_div falls; control moves only there,
    // keeping every output stable around the clk_div rising edge seen by the BRAMs.
    assign div_wrap     = (div_cnt == CNT_W'(DIV_HALF - 1));
    assign tick         = div_wrap & clk_div;
    assign load_pending = (load_cnt < cfg_n_particles);
    assign in_ready     = tick & (state == S_LOAD) & load_pending;
    assign transfer     = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            load_cnt     <= '0;
            settle       <= '0;
            ld_we        <= '0;
            ld_addr      <= '0;
            ld_pos       <= '0;
            ld_vel       <= '0;
            mem_set      <= 1'b0;
            phase1_ready <= 1'b0;
            phase3_ready <= 1'b0;
            step_count   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_cell     <= 1'b0;
        end else if (tick) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        load_cnt   <= '0;
                        step_count <= '0;
                        err_cell   <= 1'b0;
                        mem_set    <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    ld_we <= '0;
                    if (!load_pending) begin
                        state <= S_ARM;
                    end else if (transfer) begin
                        ld_addr  <= rec_addr;
                        ld_pos   <= {1'b0, rec_pos};
                        ld_vel   <= {1'b0, rec_vel};
                        load_cnt <= load_cnt + 16'd1;
                        if (rec_cell_ok) begin
                            for (int i = 0; i < N_CELL; i++)
                                ld_we[i] <= (rec_cell == CELL_W'(i));
                        end else begin
                            err_cell <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    mem_set      <= 1'b1;
                    ld_we        <= '0;
                    settle       <= '0;
                    phase1_ready <= 1'b1;
                    state        <= S_P1;
                end
                S_P1: begin
                    // Force results are trusted only after the settle window has elapsed.
                    if (phase1_done_in && settle == SET_W'(SETTLE)) begin
                        phase1_ready <= 1'b0;
                        phase3_ready <= 1'b1;
                        state        <= S_P3;
                    end else if (settle != SET_W'(SETTLE)) begin
                        settle <= settle + SET_W'(1);
                    end
                end
                S_P3: begin
                    if (&phase3_done_in) begin
                        step_count   <= step_count + STEP_W'(1);
                        phase3_ready <= 1'b0;
                        if (cfg_n_steps != '0 && step_count + STEP_W'(1) == cfg_n_steps) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            settle       <= '0;
                            phase1_ready <= 1'b1;
                            state        <= S_P1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_step_sequencer.sv
// Randomised scenario bench for md_step_sequencer; expected values come from a
// record-level model (one-hot per record, settle/step counts from the parameters).
module tb_md_step_sequencer;

    localparam int N_CELL   = 27;
    localparam int CELL_W   = 8;
    localparam int ADDR_W   = 9;
    localparam int PW       = 96;
    localparam int DIV_HALF = 8;
    localparam int SETTLE   = 99;
    localparam int STEP_W   = 16;
    localparam int IN_W     = 2*PW + CELL_W + ADDR_W;

    logic                fast_clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [15:0]         cfg_n_particles = '0;
    logic [STEP_W-1:0]   cfg_n_steps = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [IN_W-1:0]     in_data = '0;
    logic                phase1_done_in = 1'b0;
    logic [N_CELL-1:0]   phase3_done_in = '0;
    logic                clk_div;
    logic                tick;
    logic [N_CELL-1:0]   ld_we;
    logic [ADDR_W-1:0]   ld_addr;
    logic [PW:0]         ld_pos;
    logic [PW:0]         ld_vel;
    logic                mem_set;
    logic                phase1_ready;
    logic                phase3_ready;
    logic [STEP_W-1:0]   step_count;
    logic                busy;
    logic                done;
    logic                err_cell;

    md_step_sequencer #(
        .N_CELL(N_CELL), .CELL_W(CELL_W), .ADDR_W(ADDR_W), .PW(PW),
        .DIV_HALF(DIV_HALF), .SETTLE(SETTLE), .STEP_W(STEP_W)
    ) dut (
        .fast_clk(fast_clk), .reset(reset), .start(start),
        .cfg_n_particles(cfg_n_particles), .cfg_n_steps(cfg_n_steps),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .phase1_done_in(phase1_done_in), .phase3_done_in(phase3_done_in),
        .clk_div(clk_div), .tick(tick), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_pos(ld_pos), .ld_vel(ld_vel), .mem_set(mem_set),
        .phase1_ready(phase1_ready), .phase3_ready(phase3_ready),
        .step_count(step_count), .busy(busy), .done(done), .err_cell(err_cell)
    );

    always #5 fast_clk = ~fast_clk;

    int   checks = 0;
    int   errors = 0;
    logic rdy_at_tick;
    int   cells[$];
    int   addrs[$];

    // Advance to just after the next tick edge; in_ready is captured during the tick cycle.
    task automatic next_tick();
        int guard = 0;
        @(negedge fast_clk);
        while (tick !== 1'b1 && guard < 4*DIV_HALF) begin
            @(negedge fast_clk);
            guard++;
        end
        if (tick !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tick_timeout: no tick within %0d fast cycles", 4*DIV_HALF);
        end
        rdy_at_tick = in_ready;
        @(posedge fast_clk);
        #1;
    endtask

    task automatic wait_phase3(output int n);
        n = 0;
        while (phase3_ready !== 1'b1 && n < SETTLE + 20) begin
            next_tick();
            n++;
        end
    endtask

    function automatic logic [N_CELL-1:0] all_but_13();
        logic [N_CELL-1:0] m;
        m = '1;
        m[13] = 1'b0;
        return m;
    endfunction

    // Drives one load from IDLE/DONE through ARM into P1, checking every record write.
    task automatic do_load(input int n);
        logic [PW-1:0]     pos, vel;
        logic [N_CELL-1:0] exp_we;
        logic              exp_err;
        int                i, guard;
        exp_err = 1'b0;
        i = 0;
        guard = 0;
        cfg_n_particles = 16'(n);
        pos = {$urandom(), $urandom(), $urandom()};
        vel = {$urandom(), $urandom(), $urandom()};
        if (n > 0) begin
            in_data  = {ADDR_W'(addrs[0]), CELL_W'(cells[0]), vel, pos};
            in_valid = 1'b1;
        end
        start = 1'b1;
        next_tick();
        start = 1'b0;
        checks++;
        if (rdy_at_tick !== 1'b0) begin
            errors++;
            $display("FAIL start_tick_ready: in_ready=%b required 0", rdy_at_tick);
        end
        checks++;
        if ({busy, done, mem_set, err_cell} !== 4'b1000 || step_count !== '0) begin
            errors++;
            $display("FAIL enter_load: busy/done/mem_set/err=%b%b%b%b step=%0d required 1000 step 0",
                     busy, done, mem_set, err_cell, step_count);
        end
        while (i < n && guard < 4*n + 4) begin
            next_tick();
            guard++;
            if (rdy_at_tick === 1'b1) begin
                exp_we = (cells[i] < N_CELL) ? (N_CELL'(1) << cells[i]) : '0;
                if (cells[i] >= N_CELL) exp_err = 1'b1;
                checks++;
                if (ld_we !== exp_we || ld_addr !== ADDR_W'(addrs[i]) ||
                    ld_pos !== {1'b0, pos} || ld_vel !== {1'b0, vel} || err_cell !== exp_err) begin
                    errors++;
                    $display("FAIL record_%0d: we=%h addr=%0d pos=%h vel=%h err=%b required we=%h addr=%0d pos=%h vel=%h err=%b",
                             i, ld_we, ld_addr, ld_pos, ld_vel, err_cell,
                             exp_we, addrs[i], {1'b0, pos}, {1'b0, vel}, exp_err);
                end
                i++;
                if (i < n) begin
                    pos = {$urandom(), $urandom(), $urandom()};
                    vel = {$urandom(), $urandom(), $urandom()};
                    in_data = {ADDR_W'(addrs[i]), CELL_W'(cells[i]), vel, pos};
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL load_count: accepted %0d records required %0d", i, n);
        end
        next_tick();
        checks++;
        if (ld_we !== '0 || err_cell !== exp_err || phase1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_state: we=%h err=%b p1=%b busy=%b required we=0 err=%b p1=0 busy=1",
                     ld_we, err_cell, phase1_ready, busy, exp_err);
        end
        next_tick();
        checks++;
        if ({mem_set, phase1_ready, phase3_ready, err_cell} !== {3'b110, exp_err}) begin
            errors++;
            $display("FAIL enter_p1: mem_set/p1/p3/err=%b%b%b%b required 110%b",
                     mem_set, phase1_ready, phase3_ready, err_cell, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge fast_clk);
        #1;
        checks++;
        if ({clk_div, tick, in_ready, mem_set, phase1_ready, phase3_ready, busy, done, err_cell} !== '0 ||
            ld_we !== '0 || ld_addr !== '0 || ld_pos !== '0 || ld_vel !== '0 || step_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: div=%b tick=%b rdy=%b we=%h addr=%0d mem=%b p1=%b p3=%b step=%0d busy=%b done=%b err=%b required all 0",
                     clk_div, tick, in_ready, ld_we, ld_addr, mem_set, phase1_ready, phase3_ready,
                     step_count, busy, done, err_cell);
        end
    endtask

    task automatic test_divider();
        int   first_tick = -1, second_tick = -1, rise1 = -1, rise2 = -1, ticks = 0;
        logic prev_div;
        @(negedge fast_clk);
        reset = 1'b0;
        prev_div = clk_div;
        for (int c = 1; c <= 40; c++) begin
            @(posedge fast_clk);
            #1;
            if (tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = c;
                else if (second_tick < 0) second_tick = c;
            end
            if (clk_div === 1'b1 && prev_div === 1'b0) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            prev_div = clk_div;
        end
        checks++;
        if (first_tick != 2*DIV_HALF - 1) begin
            errors++;
            $display("FAIL first_tick: cycle %0d required %0d", first_tick, 2*DIV_HALF - 1);
        end
        checks++;
        if (second_tick - first_tick != 2*DIV_HALF || ticks != 2) begin
            errors++;
            $display("FAIL tick_period: spacing %0d count %0d required spacing %0d count 2",
                     second_tick - first_tick, ticks, 2*DIV_HALF);
        end
        checks++;
        if (rise2 - rise1 != 2*DIV_HALF || busy !== 1'b0) begin
            errors++;
            $display("FAIL clk_div_period: %0d busy=%b required %0d busy 0",
                     rise2 - rise1, busy, 2*DIV_HALF);
        end
    endtask

    task automatic test_load();
        cells = '{0, 5, 26};
        addrs = '{1, 2, 3};
        cfg_n_steps    = STEP_W'(2);
        phase1_done_in = 1'b1;
        phase3_done_in = all_but_13();
        do_load(3);
    endtask

    task automatic test_settle();
        int n;
        wait_phase3(n);
        checks++;
        if (n != SETTLE + 1 || phase1_ready !== 1'b0) begin
            errors++;
            $display("FAIL settle_ticks: %0d ticks p1=%b required %0d ticks p1=0", n, phase1_ready, SETTLE + 1);
        end
    endtask

    task automatic test_steps();
        int hold, n;
        for (int s = 0; s < int'(cfg_n_steps); s++) begin
            hold = (s == 0) ? 5 : int'($urandom_range(1, 4));
            phase3_done_in = all_but_13();
            for (int h = 0; h < hold; h++) begin
                next_tick();
                checks++;
                if (phase3_ready !== 1'b1 || step_count !== STEP_W'(s)) begin
                    errors++;
                    $display("FAIL p3_hold_%0d_%0d: p3=%b step=%0d required p3=1 step=%0d",
                             s, h, phase3_ready, step_count, s);
                end
            end
            phase3_done_in = '1;
            next_tick();
            checks++;
            if (step_count !== STEP_W'(s + 1)) begin
                errors++;
                $display("FAIL step_count_%0d: %0d required %0d", s, step_count, s + 1);
            end
            if (s + 1 == int'(cfg_n_steps)) begin
                checks++;
                if ({done, busy, phase1_ready, phase3_ready} !== 4'b1000) begin
                    errors++;
                    $display("FAIL done_state: done/busy/p1/p3=%b%b%b%b required 1000",
                             done, busy, phase1_ready, phase3_ready);
                end
            end else begin
                checks++;
                if ({done, phase1_ready, phase3_ready} !== 3'b010) begin
                    errors++;
                    $display("FAIL back_to_p1: done/p1/p3=%b%b%b required 010",
                             done, phase1_ready, phase3_ready);
                end
                phase3_done_in = all_but_13();
                wait_phase3(n);
                checks++;
                if (n != SETTLE + 1) begin
                    errors++;
                    $display("FAIL resettle: %0d ticks required %0d", n, SETTLE + 1);
                end
            end
        end
    endtask

    task automatic test_bad_cell();
        int n;
        cells = '{int'($urandom_range(0, N_CELL - 1)), 30};
        addrs = '{int'($urandom_range(0, 511)), int'($urandom_range(0, 511))};
        cfg_n_steps    = STEP_W'(1);
        phase3_done_in = '1;
        do_load(2);
        wait_phase3(n);
        next_tick();
        checks++;
        if (done !== 1'b1 || step_count !== STEP_W'(1) || err_cell !== 1'b1) begin
            errors++;
            $display("FAIL bad_cell_run: done=%b step=%0d err=%b required done 1 step 1 err 1",
                     done, step_count, err_cell);
        end
    endtask

    task automatic test_reset_mid_p3();
        int n;
        cells.delete();
        addrs.delete();
        for (int i = 0; i < 4; i++) begin
            cells.push_back(int'($urandom_range(0, N_CELL - 1)));
            addrs.push_back(int'($urandom_range(0, 511)));
        end
        cfg_n_steps    = STEP_W'(3);
        phase3_done_in = all_but_13();
        do_load(4);
        wait_phase3(n);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({clk_div, tick, in_ready, mem_set, phase1_ready, phase3_ready, busy, done, err_cell} !== '0 ||
            ld_we !== '0 || ld_addr !== '0 || ld_pos !== '0 || ld_vel !== '0 || step_count !== '0) begin
            errors++;
            $display("FAIL async_reset: div=%b mem=%b p1=%b p3=%b step=%0d busy=%b done=%b required all 0",
                     clk_div, mem_set, phase1_ready, phase3_ready, step_count, busy, done);
        end
        repeat (3) @(posedge fast_clk);
        @(negedge fast_clk);
        reset = 1'b0;
        phase3_done_in = '1;
        repeat (3) next_tick();
        checks++;
        if (busy !== 1'b0 || phase1_ready !== 1'b0 || phase3_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: busy=%b p1=%b p3=%b required 000", busy, phase1_ready, phase3_ready);
        end
        cells = '{int'($urandom_range(0, N_CELL - 1)), int'($urandom_range(0, N_CELL - 1))};
        addrs = '{int'($urandom_range(0, 511)), int'($urandom_range(0, 511))};
        do_load(2);
    endtask

    task automatic test_zero_particles();
        reset = 1'b1;
        repeat (2) @(posedge fast_clk);
        @(negedge fast_clk);
        reset = 1'b0;
        cells.delete();
        addrs.delete();
        do_load(0);
    endtask

    initial begin
        test_reset();
        test_divider();
        test_load();
        test_settle();
        test_steps();
        test_bad_cell();
        test_reset_mid_p3();
        test_zero_particles();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_step_sequencer.md
# md_step_sequencer

Parametrised front-end and timestep sequencer for the MD simulator core. It derives the slow compute clock from `fast_clk`, streams initial particle records into the per-cell position/velocity BRAM write ports, and sequences phase 1 (force) and phase 3 (motion update) for a programmable number of timesteps. It generalises the current fixed divide-by-16, fixed-particle-count, free-running top with:
- configurable divide ratio,
- a valid/ready load handshake,
- runtime particle and step counts,
- a configurable phase-1 settle delay,
- out-of-range cell detection.

## Interface
Parameters:
- N_CELL, 27, number of cells (BRAM pairs, phase done lanes)
- CELL_W, 8, cell index field width
- ADDR_W, 9, BRAM address width
- PW, 96, position/velocity payload width (BRAM word = PW+1, MSB 0)
- DIV_HALF, 8, fast_clk cycles per clk_div half period (≥2)
- SETTLE, 99, minimum slow ticks spent in P1 before phase1_done is honoured
- STEP_W, 16, step counter width

Ports:
- fast_clk  in  1  master clock
- reset  in  1  asynchronous, active-high
- start  in  1  level, sampled on tick; begins load from IDLE or DONE
- cfg_n_particles  in  16  records to load
- cfg_n_steps  in  STEP_W  timesteps to run; 0 = run forever
- in_valid  in  1  load record valid
- in_ready  out  1  load record accepted this fast cycle
- in_data  in  2*PW+CELL_W+ADDR_W  [PW-1:0] pos, [2PW-1:PW] vel, [2PW+:CELL_W] cell, [2PW+CELL_W+:ADDR_W] addr
- phase1_done_in  in  1  phase-1 engine done
- phase3_done_in  in  N_CELL  per-cell phase-3 done
- clk_div  out  1  slow clock for BRAMs and phase engines
- tick  out  1  one fast_clk pulse per slow period (control update edge)
- ld_we  out  N_CELL  one-hot load write enable
- ld_addr  out  ADDR_W  load write address
- ld_pos, ld_vel  out  PW+1  load write data, {1'b0, payload}
- mem_set  out  1  memory loaded; high from ARM onward until next load
- phase1_ready, phase3_ready  out  1  phase enables (mutually exclusive)
- step_count  out  STEP_W  completed timesteps
- busy  out  1  state ∉ {IDLE, DONE}
- done  out  1  state == DONE
- err_cell  out  1  sticky: a record had cell ≥ N_CELL

## Operation
- Divider:
  - 0..DIV_HALF-1 counter on fast_clk; clk_div toggles when counter == DIV_HALF-1.
  - tick = (counter == DIV_HALF-1) & clk_div, i.e. the fast edge where clk_div falls.
- All control registers update only on fast_clk edges with tick = 1, so outputs are stable half a slow period either side of each clk_div rising edge.
- States: IDLE, LOAD, ARM, P1, P3, DONE.
- IDLE/DONE: on start → LOAD.
  - Clears the load count, step_count, err_cell and mem_set.
  - done drops on leaving DONE.
- LOAD:
  - in_ready = tick & (state == LOAD) & (load count < cfg_n_particles).
  - Transfer = in_valid & in_ready.
  - On transfer, register ld_addr/ld_pos/ld_vel and set ld_we[cell] for exactly one slow period; load count += 1.
  - cell ≥ N_CELL: record consumed and counted, ld_we stays 0, err_cell ← 1.
  - When load count == cfg_n_particles at a tick → ARM. cfg_n_particles == 0 → ARM on the first tick.
- ARM: one tick. mem_set ← 1, ld_we ← 0 → P1, with settle counter cleared.
- P1:
  - phase1_ready = 1.
  - The settle counter increments each tick, saturating at SETTLE.
  - Exit to P3 when phase1_done_in & (settle == SETTLE).
- P3:
  - phase3_ready = 1.
  - Exit when &phase3_done_in. step_count += 1.
  - If cfg_n_steps ≠ 0 and step_count+1 == cfg_n_steps → DONE; else → P1 (settle cleared).
- step_count wraps modulo 2^STEP_W when cfg_n_steps == 0.
- cfg_* are sampled live; they must be held constant while busy.

## Timing
- Reset (async): counter 0, clk_div 0, tick 0, state IDLE. All other outputs 0: in_ready, ld_we, ld_addr, ld_pos, ld_vel, mem_set, phase1_ready, phase3_ready, step_count, busy, done, err_cell.
- Reset mid-run aborts immediately. Nothing resumes; start is required.
- Slow period = 2·DIV_HALF fast cycles. First tick occurs 2·DIV_HALF-1 fast cycles after reset release.
- Load throughput: at most 1 record per slow period.
- ld_we is valid from the transfer tick to the next tick, covering exactly one clk_div rising edge.
- Each state transition takes effect at one tick. Phase outputs change only on ticks.
- Minimum P1 residency: SETTLE+1 ticks.
- Simultaneous start and in_valid in IDLE: no transfer until in LOAD; in_ready is 0 on that tick.
- phase1_done_in and phase3_done_in are ignored outside P1 and P3 respectively.

## Test plan
- Divider: DIV_HALF=8, release reset → clk_div period 16 fast cycles, first tick at fast cycle 15, tick width 1.
- Load: cfg_n_particles=3, records to cells 0, 5, 26 at addr 1, 2, 3 with in_valid held → ld_we = 1<<0, 1<<5, 1<<26 on successive slow periods, ld_pos MSB 0; ARM after the 3rd record, mem_set=1.
- Bad cell: record cell=30 among 2 records → err_cell=1, no ld_we for that record, still reaches ARM.
- Settle: phase1_done_in=1 from entry into P1, SETTLE=99 → phase3_ready asserts on the 100th tick in P1.
- Steps: cfg_n_steps=2, phase3_done_in all-ones except bit 13 held low for 5 ticks → P3 held until bit 13 rises; done=1 with step_count=2 after the 2nd P3.
- Reset mid-P3 → all outputs return to reset values asynchronously; start then reloads cleanly with step_count=0.
